// File: rtl/cdr_pkg.sv
// Shared widths, FSM state and decision types for the CDR phase-code generator.
package cdr_pkg;

  localparam int unsigned CODE_W = 11;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned FREQ_W = 12;
  localparam int unsigned PH_W   = CODE_W + FRAC_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } cdr_state_e;

  typedef logic signed [1:0] cdr_dec_t;

  localparam cdr_dec_t DEC_NEG  = 2'b11;
  localparam cdr_dec_t DEC_ZERO = 2'b00;
  localparam cdr_dec_t DEC_POS  = 2'b01;

  // Clamp a widened frequency sum to +/-lim and return it at register width.
  function automatic logic signed [FREQ_W-1:0] sat_freq(input logic signed [FREQ_W+1:0] x,
                                                        input int unsigned lim);
    logic signed [FREQ_W+1:0] hi;
    logic signed [FREQ_W+1:0] lo;
    hi = (FREQ_W + 2)'(lim);
    lo = -hi;
    if (x > hi) return hi[FREQ_W-1:0];
    if (x < lo) return lo[FREQ_W-1:0];
    return x[FREQ_W-1:0];
  endfunction

endpackage

// File: rtl/cdr_phase_code_gen_if.sv
// Control and status bundle between the CDR loop filter and its controller.
interface cdr_phase_code_gen_if;

  logic                              en;
  logic                              up;
  logic                              dn;
  logic                              load;
  logic [cdr_pkg::CODE_W-1:0]        code_init;
  logic [cdr_pkg::CODE_W-1:0]        Code;
  logic                              code_upd;
  logic signed [cdr_pkg::FREQ_W-1:0] freq_out;
  logic [1:0]                        state_out;
  logic                              lock;

  modport master (
    output en, up, dn, load, code_init,
    input  Code, code_upd, freq_out, state_out, lock
  );

  modport slave (
    input  en, up, dn, load, code_init,
    output Code, code_upd, freq_out, state_out, lock
  );

endinterface

// File: rtl/cdr_vote_decimator.sv
// Majority vote of bang-bang up/dn samples over DECIM-sample windows; flags the last
// sample of each window together with the sign of the window sum.
module cdr_vote_decimator
  import cdr_pkg::*;
#(
  parameter int unsigned DECIM = 8
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     sample_i,
  input  logic     clr_i,
  input  logic     up_i,
  input  logic     dn_i,
  output logic     win_end_o,
  output cdr_dec_t dec_o
);

  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned SUM_W = $clog2(DECIM + 1) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [SUM_W-1:0] sum_q, sum_d, sum_n, vote;

  always_comb begin
    vote = '0;
    if (up_i && !dn_i) vote = SUM_W'(1);
    if (dn_i && !up_i) vote = '1;
    sum_n     = sum_q + vote;
    win_end_o = sample_i && (cnt_q == LAST);

    if (sum_n[SUM_W-1])     dec_o = DEC_NEG;
    else if (sum_n != '0)   dec_o = DEC_POS;
    else                    dec_o = DEC_ZERO;

    cnt_d = cnt_q;
    sum_d = sum_q;
    if (clr_i) begin
      cnt_d = '0;
      sum_d = '0;
    end else if (sample_i) begin
      // The next window opens on the very next sample.
      if (win_end_o) begin
        cnt_d = '0;
        sum_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        sum_d = sum_n;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sum_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/cdr_phase_code_gen.sv
// Second-order CDR loop filter producing a wrapping phase-interpolator code.
// Optional lock detector enabled by defining CDR_LOCK_DET_EN.
module cdr_phase_code_gen
  import cdr_pkg::*;
#(
  parameter int unsigned DECIM       = 8,
  parameter int unsigned KP_ACQ      = 16,
  parameter int unsigned KP_TRK      = 4,
  parameter int unsigned KI          = 1,
  parameter int unsigned FREQ_MAX    = 2047,
  parameter int unsigned ACQ_WINDOWS = 64,
  parameter int unsigned LOCK_CNT    = 16
) (
  input logic                 CLK,
  input logic                 rst_n,
  cdr_phase_code_gen_if.slave bus
);

  localparam int unsigned ACQ_W = (ACQ_WINDOWS > 1) ? $clog2(ACQ_WINDOWS) : 1;
  localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_WINDOWS - 1);

  cdr_state_e               state_q, state_d;
  logic [PH_W-1:0]          phase_q, phase_d, phase_n, phase_step, kp_word;
  logic signed [FREQ_W-1:0] freq_q, freq_d, freq_n;
  logic signed [FREQ_W+1:0] freq_ext, ki_step;
  logic                     upd_q, upd_d;
  logic [ACQ_W-1:0]         acq_cnt_q, acq_cnt_d;
  logic                     win_end, upd;
  cdr_dec_t                 dec;

  cdr_vote_decimator #(
    .DECIM (DECIM)
  ) u_vote (
    .clk_i     (CLK),
    .rst_ni    (rst_n),
    .sample_i  (bus.en),
    .clr_i     (!bus.en || bus.load),
    .up_i      (bus.up),
    .dn_i      (bus.dn),
    .win_end_o (win_end),
    .dec_o     (dec)
  );

  // A load discards the window ending in the same cycle.
  assign upd = win_end && !bus.load;

  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQ;
        ACQ:     if (upd && (acq_cnt_q == ACQ_LAST)) state_d = TRACK;
        TRACK:   state_d = TRACK;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    acq_cnt_d = acq_cnt_q;
    if (bus.load || (state_d != ACQ)) acq_cnt_d = '0;
    else if (upd && (state_q == ACQ)) acq_cnt_d = acq_cnt_q + ACQ_W'(1);
  end

  always_comb begin
    kp_word = (state_q == TRACK) ? PH_W'(KP_TRK) : PH_W'(KP_ACQ);
    kp_word = kp_word << FRAC_W;
    if (dec == DEC_POS) begin
      phase_step = kp_word;
      ki_step    = (FREQ_W + 2)'(KI);
    end else if (dec == DEC_NEG) begin
      phase_step = -kp_word;
      ki_step    = -((FREQ_W + 2)'(KI));
    end else begin
      phase_step = '0;
      ki_step    = '0;
    end
    freq_ext = {{2{freq_q[FREQ_W-1]}}, freq_q};
    freq_n   = sat_freq(freq_ext + ki_step, FREQ_MAX);
    phase_n  = phase_q + phase_step + {{(PH_W - FREQ_W){freq_n[FREQ_W-1]}}, freq_n};

    phase_d = phase_q;
    freq_d  = freq_q;
    upd_d   = 1'b0;
    if (bus.load) begin
      phase_d = {bus.code_init, {FRAC_W{1'b0}}};
    end else if (upd) begin
      phase_d = phase_n;
      freq_d  = freq_n;
      upd_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      freq_q    <= '0;
      upd_q     <= 1'b0;
      acq_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      freq_q    <= freq_d;
      upd_q     <= upd_d;
      acq_cnt_q <= acq_cnt_d;
    end
  end

  assign bus.Code      = phase_q[PH_W-1:FRAC_W];
  assign bus.code_upd  = upd_q;
  assign bus.freq_out  = freq_q;
  assign bus.state_out = state_q;

`ifdef CDR_LOCK_DET_EN
  localparam int unsigned LK_W = $clog2(LOCK_CNT + 1);

  logic [LK_W-1:0] lk_cnt_q, lk_cnt_d;
  cdr_dec_t        last_q, last_d;

  // Dithering windows (zero or sign flip) count toward lock; a same-sign run means slewing.
  always_comb begin
    lk_cnt_d = lk_cnt_q;
    last_d   = last_q;
    if (state_d != TRACK) begin
      lk_cnt_d = '0;
      last_d   = DEC_ZERO;
    end else if (upd && (state_q == TRACK)) begin
      if ((dec != DEC_ZERO) && (dec == last_q)) lk_cnt_d = '0;
      else if (lk_cnt_q != LK_W'(LOCK_CNT))   lk_cnt_d = lk_cnt_q + LK_W'(1);
      if (dec != DEC_ZERO) last_d = dec;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      lk_cnt_q <= '0;
      last_q   <= DEC_ZERO;
    end else begin
      lk_cnt_q <= lk_cnt_d;
      last_q   <= last_d;
    end
  end

  assign bus.lock = (lk_cnt_q >= LK_W'(LOCK_CNT));
`else
  logic unused_lock_cnt;
  assign unused_lock_cnt = ^LOCK_CNT;
  assign bus.lock        = 1'b0;
`endif

endmodule

// File: tb/tb_cdr_phase_code_gen.sv
// Directed self-checking bench for cdr_phase_code_gen with hand-computed expectations.
module tb_cdr_phase_code_gen;
  import cdr_pkg::*;

  localparam int NS     = 8;
  localparam int P_UP   = 0;
  localparam int P_DN   = 1;
  localparam int P_ALT  = 2;
  localparam int P_BOTH = 3;
  localparam int P_NONE = 4;

  logic CLK   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  cdr_phase_code_gen_if bus ();

  cdr_phase_code_gen dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int pat, input int i);
    case (pat)
      P_UP:    begin bus.up = 1'b1; bus.dn = 1'b0; end
      P_DN:    begin bus.up = 1'b0; bus.dn = 1'b1; end
      P_ALT:   begin bus.up = (i % 2 == 0); bus.dn = (i % 2 != 0); end
      P_BOTH:  begin bus.up = 1'b1; bus.dn = 1'b1; end
      default: begin bus.up = 1'b0; bus.dn = 1'b0; end
    endcase
  endtask

  task automatic run_window(input int pat);
    for (int i = 0; i < NS; i++) begin
      drive(pat, i);
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.Code !== 11'd0) begin errors++; $display("FAIL rst_code got %0d want 0", bus.Code); end
    checks++; if (bus.freq_out !== 12'sd0) begin errors++; $display("FAIL rst_freq got %0d want 0", bus.freq_out); end
    checks++; if (bus.code_upd !== 1'b0) begin errors++; $display("FAIL rst_upd got %b want 0", bus.code_upd); end
    checks++; if (bus.state_out !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", bus.state_out); end
    checks++; if (bus.lock !== 1'b0) begin errors++; $display("FAIL rst_lock got %b want 0", bus.lock); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_first_window();
    bus.en = 1'b1;
    for (int i = 0; i < NS; i++) begin
      drive(P_UP, i);
      step();
      if (i == 0) begin
        checks++; if (bus.state_out !== 2'd1) begin errors++; $display("FAIL w1_enter_acq got %0d want 1", bus.state_out); end
      end
      if (i < NS - 1) begin
        checks++; if (bus.code_upd !== 1'b0) begin errors++; $display("FAIL w1_early_upd i=%0d got %b want 0", i, bus.code_upd); end
      end
    end
    checks++; if (bus.code_upd !== 1'b1) begin errors++; $display("FAIL w1_upd got %b want 1", bus.code_upd); end
    checks++; if (bus.Code !== 11'd16) begin errors++; $display("FAIL w1_code got %0d want 16", bus.Code); end
    checks++; if (bus.freq_out !== 12'sd1) begin errors++; $display("FAIL w1_freq got %0d want 1", bus.freq_out); end
    checks++; if (bus.state_out !== 2'd1) begin errors++; $display("FAIL w1_state got %0d want 1", bus.state_out); end
  endtask

  task automatic test_alternating();
    for (int i = 0; i < NS; i++) begin
      drive(P_ALT, i);
      step();
      if (i == 0) begin
        checks++; if (bus.code_upd !== 1'b0) begin errors++; $display("FAIL upd_one_cycle got %b want 0", bus.code_upd); end
      end
    end
    checks++; if (bus.code_upd !== 1'b1) begin errors++; $display("FAIL alt_upd got %b want 1", bus.code_upd); end
    checks++; if (bus.Code !== 11'd16) begin errors++; $display("FAIL alt_code got %0d want 16", bus.Code); end
    checks++; if (bus.freq_out !== 12'sd1) begin errors++; $display("FAIL alt_freq got %0d want 1", bus.freq_out); end
  endtask

  task automatic test_acq_to_track();
    for (int w = 3; w <= 64; w++) begin
      run_window(P_BOTH);
      if (w == 63) begin
        checks++; if (bus.state_out !== 2'd1) begin errors++; $display("FAIL acq_w63 got %0d want 1", bus.state_out); end
      end
    end
    checks++; if (bus.state_out !== 2'd2) begin errors++; $display("FAIL track_w64 got %0d want 2", bus.state_out); end
    checks++; if (bus.Code !== 11'd16) begin errors++; $display("FAIL track_code got %0d want 16", bus.Code); end
    checks++; if (bus.freq_out !== 12'sd1) begin errors++; $display("FAIL track_freq got %0d want 1", bus.freq_out); end
  endtask

  task automatic test_load_wrap();
    run_window(P_DN);
    checks++; if (bus.freq_out !== 12'sd0) begin errors++; $display("FAIL trk_dn_freq got %0d want 0", bus.freq_out); end
    checks++; if (bus.Code !== 11'd12) begin errors++; $display("FAIL trk_dn_code got %0d want 12", bus.Code); end
    drive(P_NONE, 0);
    bus.load = 1'b1; bus.code_init = 11'd2046;
    step();
    bus.load = 1'b0;
    checks++; if (bus.Code !== 11'd2046) begin errors++; $display("FAIL load_code got %0d want 2046", bus.Code); end
    checks++; if (bus.code_upd !== 1'b0) begin errors++; $display("FAIL load_upd got %b want 0", bus.code_upd); end
    run_window(P_UP);
    checks++; if (bus.Code !== 11'd2) begin errors++; $display("FAIL wrap_up_code got %0d want 2", bus.Code); end
    checks++; if (bus.freq_out !== 12'sd1) begin errors++; $display("FAIL wrap_up_freq got %0d want 1", bus.freq_out); end
    drive(P_NONE, 0);
    bus.load = 1'b1; bus.code_init = 11'd0;
    step();
    bus.load = 1'b0;
    run_window(P_DN);
    checks++; if (bus.Code !== 11'd2044) begin errors++; $display("FAIL wrap_dn_code got %0d want 2044", bus.Code); end
    checks++; if (bus.freq_out !== 12'sd0) begin errors++; $display("FAIL wrap_dn_freq got %0d want 0", bus.freq_out); end
  endtask

  task automatic test_load_priority();
    for (int i = 0; i < NS; i++) begin
      drive(P_UP, i);
      if (i == NS - 1) begin
        bus.load = 1'b1; bus.code_init = 11'd100;
      end
      step();
    end
    bus.load = 1'b0;
    checks++; if (bus.code_upd !== 1'b0) begin errors++; $display("FAIL ldpri_upd got %b want 0", bus.code_upd); end
    checks++; if (bus.Code !== 11'd100) begin errors++; $display("FAIL ldpri_code got %0d want 100", bus.Code); end
    checks++; if (bus.freq_out !== 12'sd0) begin errors++; $display("FAIL ldpri_freq got %0d want 0", bus.freq_out); end
    checks++; if (bus.state_out !== 2'd2) begin errors++; $display("FAIL ldpri_state got %0d want 2", bus.state_out); end
  endtask

  task automatic test_en_drop();
    for (int i = 0; i < 3; i++) begin
      drive(P_UP, i);
      step();
    end
    bus.en = 1'b0;
    step();
    checks++; if (bus.state_out !== 2'd0) begin errors++; $display("FAIL endrop_state got %0d want 0", bus.state_out); end
    checks++; if (bus.Code !== 11'd100) begin errors++; $display("FAIL endrop_code got %0d want 100", bus.Code); end
    checks++; if (bus.code_upd !== 1'b0) begin errors++; $display("FAIL endrop_upd got %b want 0", bus.code_upd); end
    repeat (3) step();
    checks++; if (bus.Code !== 11'd100) begin errors++; $display("FAIL idle_hold_code got %0d want 100", bus.Code); end
    bus.en = 1'b1;
    run_window(P_UP);
    checks++; if (bus.code_upd !== 1'b1) begin errors++; $display("FAIL reen_upd got %b want 1", bus.code_upd); end
    checks++; if (bus.Code !== 11'd116) begin errors++; $display("FAIL reen_code got %0d want 116", bus.Code); end
    checks++; if (bus.freq_out !== 12'sd1) begin errors++; $display("FAIL reen_freq got %0d want 1", bus.freq_out); end
    checks++; if (bus.state_out !== 2'd1) begin errors++; $display("FAIL reen_state got %0d want 1", bus.state_out); end
  endtask

  task automatic test_saturate();
    for (int w = 1; w <= 2050; w++) begin
      run_window(P_UP);
      if (w == 2045) begin
        checks++; if (bus.freq_out !== 12'sd2046) begin errors++; $display("FAIL sat_pre got %0d want 2046", bus.freq_out); end
      end
      if (w == 2046) begin
        checks++; if (bus.freq_out !== 12'sd2047) begin errors++; $display("FAIL sat_hit got %0d want 2047", bus.freq_out); end
      end
    end
    checks++; if (bus.freq_out !== 12'sd2047) begin errors++; $display("FAIL sat_hold got %0d want 2047", bus.freq_out); end
    run_window(P_DN);
    checks++; if (bus.freq_out !== 12'sd2046) begin errors++; $display("FAIL sat_dn got %0d want 2046", bus.freq_out); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(P_UP, i);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.Code !== 11'd0) begin errors++; $display("FAIL rmid_code got %0d want 0", bus.Code); end
    checks++; if (bus.freq_out !== 12'sd0) begin errors++; $display("FAIL rmid_freq got %0d want 0", bus.freq_out); end
    checks++; if (bus.state_out !== 2'd0) begin errors++; $display("FAIL rmid_state got %0d want 0", bus.state_out); end
    checks++; if (bus.code_upd !== 1'b0) begin errors++; $display("FAIL rmid_upd got %b want 0", bus.code_upd); end
    bus.en = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    bus.en = 1'b1;
    for (int w = 1; w <= 64; w++) run_window(P_NONE);
    checks++; if (bus.state_out !== 2'd2) begin errors++; $display("FAIL lk_track got %0d want 2", bus.state_out); end
    for (int w = 1; w <= 16; w++) begin
      run_window((w % 2 == 1) ? P_UP : P_DN);
`ifdef CDR_LOCK_DET_EN
      if (w == 15) begin
        checks++; if (bus.lock !== 1'b0) begin errors++; $display("FAIL lk_w15 got %b want 0", bus.lock); end
      end
`endif
    end
`ifdef CDR_LOCK_DET_EN
    checks++; if (bus.lock !== 1'b1) begin errors++; $display("FAIL lk_w16 got %b want 1", bus.lock); end
    run_window(P_UP);
    checks++; if (bus.lock !== 1'b1) begin errors++; $display("FAIL lk_w17 got %b want 1", bus.lock); end
    run_window(P_UP);
    checks++; if (bus.lock !== 1'b0) begin errors++; $display("FAIL lk_repeat got %b want 0", bus.lock); end
`else
    checks++; if (bus.lock !== 1'b0) begin errors++; $display("FAIL lk_tied got %b want 0", bus.lock); end
`endif
  endtask

  initial begin
    bus.en = 1'b0; bus.up = 1'b0; bus.dn = 1'b0; bus.load = 1'b0; bus.code_init = '0;
    test_reset();
    test_first_window();
    test_alternating();
    test_acq_to_track();
    test_load_wrap();
    test_load_priority();
    test_en_drop();
    test_saturate();
    test_reset_mid();
    test_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
